// File: rtl/pixel_block_average.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_block_average
//  Purpose  : Streaming BLK x BLK block-average downsampler. Raster-order
//             pixels are summed horizontally into hacc, block-row partial
//             sums live in a single-row line buffer of OUT_W entries. Each
//             completed block gives an average, a threshold mask bit and a
//             bitmap address.
//             Pipeline: the edge that accepts a block's last pixel loads the
//             full sum into stage 1. The next edge loads the reciprocal
//             product into stage 2. The edge after that registers the
//             outputs, so results appear two edges after that pixel.
//  Options  : PIXEL_BLOCK_AVERAGE_FLIP_EN - when defined, addr_out counts
//             down from OUT_W*OUT_H-1 for the reversed plotter readout.
//  Revision : 1.0 - initial release
// ============================================================================
module pixel_block_average #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 320,
    parameter int IMG_H = 240,
    parameter int BLK   = 3,
    localparam int OUT_W  = IMG_W / BLK,
    localparam int OUT_H  = IMG_H / BLK,
    localparam int NBLK   = OUT_W * OUT_H,
    localparam int ADDR_W = (NBLK > 1) ? $clog2(NBLK) : 1
) (
    input  logic              clk_in,
    input  logic              rst_in_n,
    input  logic              data_valid_in,
    input  logic [PIX_W-1:0]  pixel_in,
    input  logic [10:0]       hcount_in,
    input  logic [9:0]        vcount_in,
    input  logic [PIX_W-1:0]  threshold_in,
    output logic              data_valid_out,
    output logic [PIX_W-1:0]  avg_out,
    output logic              mask_out,
    output logic [ADDR_W-1:0] addr_out,
    output logic              frame_done_out
);

    localparam int SUM_W  = PIX_W + $clog2(BLK * BLK);
    localparam int RECIP  = (65536 + BLK * BLK - 1) / (BLK * BLK);
    localparam int PROD_W = SUM_W + 17;
    localparam int QUOT_W = PROD_W - 16;
    localparam int CP_W   = (BLK > 1) ? $clog2(BLK) : 1;
    localparam int BC_W   = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int BR_W   = (OUT_H > 1) ? $clog2(OUT_H) : 1;

    localparam logic [CP_W-1:0]   C_BLK_LAST = CP_W'(BLK - 1);
    localparam logic [BC_W-1:0]   C_BC_LAST  = BC_W'(OUT_W - 1);
    localparam logic [BR_W-1:0]   C_BR_LAST  = BR_W'(OUT_H - 1);
    localparam logic [10:0]       C_COL_LAST = 11'(IMG_W - 1);
    localparam logic [10:0]       C_ACT_W    = 11'(OUT_W * BLK);
    localparam logic [9:0]        C_ACT_H    = 10'(OUT_H * BLK);
    localparam logic [PROD_W-1:0] C_RECIP    = PROD_W'(RECIP);
    localparam logic [QUOT_W-1:0] C_PIX_MAX  = QUOT_W'((1 << PIX_W) - 1);
    localparam logic [ADDR_W-1:0] C_ADDR_TOP = ADDR_W'(NBLK - 1);

    // Frame position and accumulation state
    logic              synced_q;
    logic [CP_W-1:0]   col_phase_q;
    logic [CP_W-1:0]   row_phase_q;
    logic [BC_W-1:0]   blk_col_q;
    logic [BR_W-1:0]   blk_row_q;
    logic [SUM_W-1:0]  hacc_q;
    logic [SUM_W-1:0]  line_buf_q [OUT_W];

    // Pipeline registers
    logic              s1_valid_q;
    logic [SUM_W-1:0]  s1_sum_q;
    logic [ADDR_W-1:0] s1_addr_q;
    logic              s1_last_q;
    logic              s2_valid_q;
    logic [QUOT_W-1:0] s2_quot_q;
    logic [ADDR_W-1:0] s2_addr_q;
    logic              s2_last_q;

    // Combinational decode of the current pixel
    logic              w_origin;
    logic              w_live;
    logic              w_in_region;
    logic              w_accept;
    logic [CP_W-1:0]   w_col_phase;
    logic [CP_W-1:0]   w_row_phase;
    logic [BC_W-1:0]   w_blk_col;
    logic [BR_W-1:0]   w_blk_row;
    logic [SUM_W-1:0]  w_hacc;
    logic [SUM_W-1:0]  w_entry;
    logic [SUM_W-1:0]  w_full_sum;
    logic              w_blk_done;
    logic              w_last_row;
    logic              w_last_blk;
    logic [ADDR_W-1:0] w_addr_lin;
    logic [ADDR_W-1:0] w_addr;
    logic [PROD_W-1:0] w_prod;
    logic [PIX_W-1:0]  w_avg;

    // Effective counters see the hcount==0 / (0,0) reloads in the same cycle
    always_comb begin
        w_origin    = data_valid_in && (hcount_in == '0) && (vcount_in == '0);
        w_live      = data_valid_in && (synced_q || w_origin);
        w_in_region = (hcount_in < C_ACT_W) && (vcount_in < C_ACT_H);
        w_accept    = w_live && w_in_region;
        w_col_phase = (hcount_in == '0) ? '0 : col_phase_q;
        w_blk_col   = (hcount_in == '0) ? '0 : blk_col_q;
        w_row_phase = w_origin ? '0 : row_phase_q;
        w_blk_row   = w_origin ? '0 : blk_row_q;
        w_hacc      = ((w_col_phase == '0) ? '0 : hacc_q) + SUM_W'(pixel_in);
        w_entry     = line_buf_q[w_blk_col];
        w_full_sum  = w_entry + w_hacc;
        w_blk_done  = w_accept && (w_col_phase == C_BLK_LAST);
        w_last_row  = (w_row_phase == C_BLK_LAST);
        w_last_blk  = (w_blk_col == C_BC_LAST) && (w_blk_row == C_BR_LAST);
        w_addr_lin  = ADDR_W'(w_blk_row * OUT_W + w_blk_col);
`ifdef PIXEL_BLOCK_AVERAGE_FLIP_EN
        w_addr      = C_ADDR_TOP - w_addr_lin;
`else
        w_addr      = w_addr_lin;
`endif
        w_prod      = PROD_W'(s1_sum_q) * C_RECIP;
        w_avg       = (s2_quot_q > C_PIX_MAX) ? C_PIX_MAX[PIX_W-1:0]
                                              : s2_quot_q[PIX_W-1:0];
    end

    // Sync flag, column/row counters and horizontal accumulator
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            synced_q    <= 1'b0;
            col_phase_q <= '0;
            row_phase_q <= '0;
            blk_col_q   <= '0;
            blk_row_q   <= '0;
            hacc_q      <= '0;
        end else if (w_live) begin
            if (w_origin) begin
                synced_q <= 1'b1;
            end
            if (w_accept) begin
                hacc_q <= w_hacc;
                if (w_col_phase == C_BLK_LAST) begin
                    col_phase_q <= '0;
                    blk_col_q   <= w_blk_col + BC_W'(1);
                end else begin
                    col_phase_q <= w_col_phase + CP_W'(1);
                    blk_col_q   <= w_blk_col;
                end
            end else begin
                col_phase_q <= w_col_phase;
                blk_col_q   <= w_blk_col;
            end
            if (hcount_in == C_COL_LAST) begin
                if (w_last_row) begin
                    row_phase_q <= '0;
                    blk_row_q   <= w_blk_row + BR_W'(1);
                end else begin
                    row_phase_q <= w_row_phase + CP_W'(1);
                    blk_row_q   <= w_blk_row;
                end
            end else begin
                row_phase_q <= w_row_phase;
                blk_row_q   <= w_blk_row;
            end
        end
    end

    // Line buffer: row 0 overwrites, middle rows accumulate, last row reads
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            for (int i = 0; i < OUT_W; i++) begin
                line_buf_q[i] <= '0;
            end
        end else if (w_blk_done && !w_last_row) begin
            if (w_row_phase == '0) begin
                line_buf_q[w_blk_col] <= w_hacc;
            end else begin
                line_buf_q[w_blk_col] <= w_full_sum;
            end
        end
    end

    // Stage 1 full sum, stage 2 reciprocal product, then registered outputs
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            s1_valid_q     <= 1'b0;
            s1_sum_q       <= '0;
            s1_addr_q      <= '0;
            s1_last_q      <= 1'b0;
            s2_valid_q     <= 1'b0;
            s2_quot_q      <= '0;
            s2_addr_q      <= '0;
            s2_last_q      <= 1'b0;
            data_valid_out <= 1'b0;
            avg_out        <= '0;
            mask_out       <= 1'b0;
            addr_out       <= '0;
            frame_done_out <= 1'b0;
        end else begin
            s1_valid_q <= w_blk_done && w_last_row;
            if (w_blk_done && w_last_row) begin
                s1_sum_q  <= w_full_sum;
                s1_addr_q <= w_addr;
                s1_last_q <= w_last_blk;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_quot_q <= QUOT_W'(w_prod >> 16);
                s2_addr_q <= s1_addr_q;
                s2_last_q <= s1_last_q;
            end
            data_valid_out <= s2_valid_q;
            frame_done_out <= s2_valid_q && s2_last_q;
            if (s2_valid_q) begin
                avg_out  <= w_avg;
                mask_out <= (w_avg >= threshold_in);
                addr_out <= s2_addr_q;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pixel_block_average.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pixel_block_average
//  Purpose  : Self-checking bench for pixel_block_average on a reduced image
//             (32x23, 3x3 blocks) with ragged right and bottom edges. The
//             reference model sums whole blocks straight from the image array.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_block_average;

    localparam int PIX_W  = 8;
    localparam int IMG_W  = 32;
    localparam int IMG_H  = 23;
    localparam int BLK    = 3;
    localparam int OUT_W  = IMG_W / BLK;
    localparam int OUT_H  = IMG_H / BLK;
    localparam int NBLK   = OUT_W * OUT_H;
    localparam int ADDR_W = $clog2(NBLK);
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int RECIP  = (65536 + BLK * BLK - 1) / (BLK * BLK);
    localparam int PMAX   = (1 << PIX_W) - 1;

    logic              clk_in = 1'b0;
    logic              rst_in_n = 1'b0;
    logic              data_valid_in = 1'b0;
    logic [PIX_W-1:0]  pixel_in = '0;
    logic [10:0]       hcount_in = '0;
    logic [9:0]        vcount_in = '0;
    logic [PIX_W-1:0]  threshold_in = '0;
    logic              data_valid_out;
    logic [PIX_W-1:0]  avg_out;
    logic              mask_out;
    logic [ADDR_W-1:0] addr_out;
    logic              frame_done_out;

    pixel_block_average #(
        .PIX_W (PIX_W),
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .BLK   (BLK)
    ) dut (
        .clk_in         (clk_in),
        .rst_in_n       (rst_in_n),
        .data_valid_in  (data_valid_in),
        .pixel_in       (pixel_in),
        .hcount_in      (hcount_in),
        .vcount_in      (vcount_in),
        .threshold_in   (threshold_in),
        .data_valid_out (data_valid_out),
        .avg_out        (avg_out),
        .mask_out       (mask_out),
        .addr_out       (addr_out),
        .frame_done_out (frame_done_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int avg;
        int mask;
        int addr;
        int fd;
        int cyc;
    } res_t;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   stray_fd = 0;
    int   img [NPIX];
    int   acc_edge [NPIX];
    res_t act_q [$];
    res_t exp_q [$];

    always @(posedge clk_in) cyc <= cyc + 1;

    // Record every strobe, with the edge count at which it became visible
    always @(negedge clk_in) begin
        if (data_valid_out === 1'b1) begin
            act_q.push_back('{int'(avg_out), int'(mask_out), int'(addr_out),
                              int'(frame_done_out), cyc});
        end else if (frame_done_out === 1'b1) begin
            stray_fd++;
        end
    end

    function automatic void fill_image(input int pattern, input int c);
        for (int idx = 0; idx < NPIX; idx++) begin
            int h = idx % IMG_W;
            int v = idx / IMG_W;
            case (pattern)
                0:       img[idx] = c;
                1:       img[idx] = int'($urandom_range(PMAX));
                2:       img[idx] = (h * 7 + v * 3) & PMAX;
                default: img[idx] = (h >= OUT_W * BLK || v >= OUT_H * BLK) ? PMAX : 0;
            endcase
        end
    endfunction

    // Expected results for every block whose last pixel lies in the driven prefix
    function automatic void add_expected(input int npix, input int thr);
        for (int by = 0; by < OUT_H; by++) begin
            for (int bx = 0; bx < OUT_W; bx++) begin
                int   li = (by * BLK + BLK - 1) * IMG_W + bx * BLK + BLK - 1;
                int   sum = 0;
                int   avg;
                int   lin = by * OUT_W + bx;
                res_t r;
                if (li < npix) begin
                    for (int y = 0; y < BLK; y++)
                        for (int x = 0; x < BLK; x++)
                            sum += img[(by * BLK + y) * IMG_W + bx * BLK + x];
                    avg = (sum * RECIP) >>> 16;
                    if (avg > PMAX) avg = PMAX;
                    r.avg  = avg;
                    r.mask = (avg >= thr) ? 1 : 0;
`ifdef PIXEL_BLOCK_AVERAGE_FLIP_EN
                    r.addr = NBLK - 1 - lin;
`else
                    r.addr = lin;
`endif
                    r.fd   = (bx == OUT_W - 1 && by == OUT_H - 1) ? 1 : 0;
                    r.cyc  = acc_edge[li] + 2;
                    exp_q.push_back(r);
                end
            end
        end
    endfunction

    // Drive raster pixels [first, last) with random idle gaps of gap_pct percent
    task automatic drive_pixels(input int first, input int last, input int gap_pct);
        for (int idx = first; idx < last; idx++) begin
            while (int'($urandom_range(99)) < gap_pct) begin
                data_valid_in = 1'b0;
                pixel_in      = PIX_W'($urandom);
                hcount_in     = '0;
                vcount_in     = '0;
                @(posedge clk_in);
                #1;
            end
            data_valid_in = 1'b1;
            pixel_in      = PIX_W'(img[idx]);
            hcount_in     = 11'(idx % IMG_W);
            vcount_in     = 10'(idx / IMG_W);
            acc_edge[idx] = cyc + 1;
            @(posedge clk_in);
            #1;
        end
        data_valid_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_in_n = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        n_cmp++;
        if (data_valid_out !== 1'b0) begin
            n_err++; $display("FAIL reset_dv got %b expected 0", data_valid_out);
        end
        n_cmp++;
        if (avg_out !== '0) begin
            n_err++; $display("FAIL reset_avg got %0d expected 0", avg_out);
        end
        n_cmp++;
        if (mask_out !== 1'b0) begin
            n_err++; $display("FAIL reset_mask got %b expected 0", mask_out);
        end
        n_cmp++;
        if (addr_out !== '0) begin
            n_err++; $display("FAIL reset_addr got %0d expected 0", addr_out);
        end
        n_cmp++;
        if (frame_done_out !== 1'b0) begin
            n_err++; $display("FAIL reset_fd got %b expected 0", frame_done_out);
        end
        rst_in_n = 1'b1;
        @(posedge clk_in);
        #1;
    endtask

    // Optional prefix (aborted frame) followed by one complete frame
    task automatic test_image(input string name, input int pattern, input int c,
                              input int thr, input int gap_pct, input int prefix);
        int n;
        fill_image(pattern, c);
        threshold_in = PIX_W'(thr);
        act_q.delete();
        exp_q.delete();
        stray_fd = 0;
        if (prefix > 0) begin
            drive_pixels(0, prefix, gap_pct);
            add_expected(prefix, thr);
        end
        drive_pixels(0, NPIX, gap_pct);
        add_expected(NPIX, thr);
        repeat (6) @(posedge clk_in);
        #1;
        n_cmp++;
        if (act_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL %s count got %0d expected %0d", name, act_q.size(), exp_q.size());
        end
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            n_cmp++;
            if (act_q[i].avg != exp_q[i].avg) begin
                n_err++;
                $display("FAIL %s[%0d] avg got %0d expected %0d", name, i, act_q[i].avg, exp_q[i].avg);
            end
            n_cmp++;
            if (act_q[i].mask != exp_q[i].mask) begin
                n_err++;
                $display("FAIL %s[%0d] mask got %0d expected %0d", name, i, act_q[i].mask, exp_q[i].mask);
            end
            n_cmp++;
            if (act_q[i].addr != exp_q[i].addr) begin
                n_err++;
                $display("FAIL %s[%0d] addr got %0d expected %0d", name, i, act_q[i].addr, exp_q[i].addr);
            end
            n_cmp++;
            if (act_q[i].fd != exp_q[i].fd) begin
                n_err++;
                $display("FAIL %s[%0d] frame_done got %0d expected %0d", name, i, act_q[i].fd, exp_q[i].fd);
            end
            n_cmp++;
            if (act_q[i].cyc != exp_q[i].cyc) begin
                n_err++;
                $display("FAIL %s[%0d] strobe_cycle got %0d expected %0d", name, i, act_q[i].cyc, exp_q[i].cyc);
            end
        end
        n_cmp++;
        if (stray_fd != 0) begin
            n_err++;
            $display("FAIL %s stray_frame_done got %0d expected 0", name, stray_fd);
        end
    endtask

    // Asynchronous reset mid-frame: outputs clear at once, rest of frame is ignored
    task automatic test_reset_midframe();
        int cut = 10 * IMG_W + 7;
        fill_image(1, 0);
        threshold_in = PIX_W'(100);
        drive_pixels(0, cut, 0);
        #3;
        rst_in_n = 1'b0;
        #1;
        n_cmp++;
        if (data_valid_out !== 1'b0 || avg_out !== '0 || mask_out !== 1'b0 ||
            addr_out !== '0 || frame_done_out !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_outputs got dv=%b avg=%0d mask=%b addr=%0d fd=%b expected all 0",
                     data_valid_out, avg_out, mask_out, addr_out, frame_done_out);
        end
        @(posedge clk_in);
        @(posedge clk_in);
        #1;
        rst_in_n = 1'b1;
        act_q.delete();
        stray_fd = 0;
        drive_pixels(cut, NPIX, 20);
        repeat (6) @(posedge clk_in);
        #1;
        n_cmp++;
        if (act_q.size() != 0 || stray_fd != 0) begin
            n_err++;
            $display("FAIL midreset_unsynced strobes got %0d (fd %0d) expected 0", act_q.size(), stray_fd);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_image("const100",  0, 100, 100, 0,  0);
        test_image("sat255",    0, 255, 255, 0,  0);
        test_image("zero_thr0", 0, 0,   0,   0,  0);
        test_image("zero_thr1", 0, 0,   1,   0,  0);
        test_image("edge",      3, 0,   1,   0,  0);
        test_image("ramp",      2, 0,   90,  0,  0);
        test_image("ramp_gaps", 2, 0,   90,  50, 0);
        test_image("random",    1, 0,   128, 30, 0);
        test_image("restart",   1, 0,   128, 25, 4 * IMG_W + 13);
        test_reset_midframe();
        test_image("post_reset", 1, 0,  60,  10, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
